alu_issue: RTL and testbench
============================

# alu_issue

Decode-and-issue stage feeding the ALU. Accepts fetched MIPS instructions plus register-file read values, decodes them into the ALU command and operand-source select, and presents registered operands (`valor1`, `valor2`, `imediato`) to the execute stage. A 2-entry skid buffer with valid/ready handshakes on both sides absorbs execute-stage stalls without dropping instructions. Flush support covers branch redirects.

## Interface
- `MULT_FUNCT`, 6'h18: R-type funct code decoded as multiply (effective only with the macro below).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `id_valid` input 1: the instruction and operand inputs are valid.
- `id_ready` output 1: the stage can accept an instruction this cycle.
- `instr` input 32: MIPS instruction word.
- `rs_val`, `rt_val` input 32 each: register-file read data.
- `flush` input 1: synchronous discard of all held and incoming instructions.
- `ex_valid` output 1: the issue outputs are valid.
- `ex_ready` input 1: the execute stage consumes the issue outputs this cycle.
- `comando` output 4: ALU command.
- `alusrc` output 1: 1 selects `imediato` as the second operand.
- `valor1`, `valor2`, `imediato` output 32 each: ALU operands.
- `wr_reg` output 5: destination register number.
- `regwrite`, `memread`, `memwrite`, `branch` output 1 each: control flags for later stages.
- `illegal` output 1: one-cycle pulse when an unknown opcode is accepted.

## Operation
- A transfer on the input side occurs when `id_valid && id_ready`. A transfer on the output side occurs when `ex_valid && ex_ready`.
- Decode (opcode/funct → `comando`, `alusrc`, immediate extension, destination, flags):
  - R-type (op 0), destination `rd`, `regwrite` set:
    - add 0x20 → 0010
    - sub 0x22 → 0110
    - and 0x24 → 0000
    - or 0x25 → 0001
    - nor 0x27 → 1100
  - addi 0x08 → 0010, `alusrc` 1, sign-extended immediate, destination `rt`.
  - andi 0x0C → 0000 and ori 0x0D → 0001; both `alusrc` 1, zero-extended immediate, destination `rt`.
  - lw 0x23 → 0010, `alusrc` 1, sign-extended, `memread` and `regwrite` set.
  - sw 0x2B → 0010, `alusrc` 1, sign-extended, `memwrite` set.
  - beq 0x04 → 0110, `alusrc` 0, sign-extended, `branch` set.
- Operand mapping: `valor1` = `rs_val`, `valor2` = `rt_val`. `imediato` always carries the extended immediate, even when `alusrc` is 0.
- Unknown opcode or funct:
  - The instruction is accepted but not enqueued.
  - `illegal` pulses on the cycle after acceptance.
- Skid buffer FSM, states EMPTY / ONE / FULL:
  - EMPTY: on accept → ONE.
  - ONE:
    - accept without consume → FULL
    - consume without accept → EMPTY
    - accept and consume together → ONE (the new entry replaces the old one).
  - FULL: on consume → ONE. No accept is possible in FULL.
- Outputs are always driven from the head entry. Entries are issued in order.

## Timing
- Reset values:
  - state EMPTY
  - `id_ready` 1
  - `ex_valid` 0
  - `illegal` 0
  - all data and flag outputs 0 (`comando` 0000).
- Latency: an instruction accepted in cycle N appears with `ex_valid` high in cycle N+1 when the buffer was empty.
- `id_ready` is registered: it is 0 exactly when the state is FULL.
- Output data remains stable while `ex_valid && !ex_ready`.
- `flush`:
  - Next state is EMPTY, `ex_valid` is 0 and `id_ready` is 1.
  - Flush takes priority over a simultaneous accept or consume; an instruction offered in the flush cycle is discarded and raises no `illegal` pulse.
- Asserting `rst_n` low mid-transfer returns the stage immediately to the reset values. Held entries are lost.

## Configuration
- `ALU_ISSUE_MULT_EN` defined: R-type funct `MULT_FUNCT` decodes to `comando` 0111, `alusrc` 0, destination `rd`, `regwrite` set.
- `ALU_ISSUE_MULT_EN` not defined: that funct is treated as unknown. It raises `illegal` and is not enqueued.

## Structure
- Shared package `alu_pkg`:
  - `comando` constants: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_MUL`, `ALU_NOR`.
  - Opcode and funct constants.
  - The decoded-entry struct typedef, used by the buffer.
- One sub-module, `alu_decode`: purely combinational, `instr` → decoded entry plus an illegal flag.
- The buffer and FSM live in `alu_issue`.

## Test plan
- add r3,r1,r2 (0x00221820) with `rs_val`=5, `rt_val`=7, `ex_ready`=1 → next cycle: `comando`=0010, `alusrc`=0, `valor1`=5, `valor2`=7, `wr_reg`=3, `regwrite`=1.
- addi with immediate 0xFFFC → `imediato`=0xFFFFFFFC, `alusrc`=1. ori with immediate 0x8001 → `imediato`=0x00008001.
- Hold `ex_ready`=0 and offer 3 instructions back to back:
  - the first two are accepted and `id_ready` drops to 0
  - the third is held off
  - raising `ex_ready` issues all three in order with unchanged data.
- `flush` while FULL, with `id_valid` also high → next cycle `ex_valid`=0 and `id_ready`=1; the offered instruction never issues.
- Opcode 0x3F → `illegal` pulses for exactly 1 cycle and `ex_valid` stays 0. funct 0x18 → `illegal` without `ALU_ISSUE_MULT_EN`, `comando`=0111 with it.
- Pull `rst_n` low while FULL → outputs return to their reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU command, opcode/funct constants and decoded-entry type for the issue stage
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] MULT_FUNCT = 6'h18;
  typedef struct packed {
    logic [3:0]  comando;
    logic        alusrc;
    logic [31:0] valor1;
    logic [31:0] valor2;
    logic [31:0] imediato;
    logic [4:0]  wr_reg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational MIPS decode into an issue entry; multiply enabled by ALU_ISSUE_MULT_EN
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output entry_t      d,
  output logic        illegal
);
  logic [5:0] op, funct;
  assign op = instr[31:26];
  assign funct = instr[5:0];
  always_comb begin
    d = '0;
    illegal = 1'b0;
    d.valor1 = rs_val;
    d.valor2 = rt_val;
    d.imediato = {{16{instr[15]}}, instr[15:0]};
    d.wr_reg = instr[20:16];
    case (op)
      OP_RTYPE: begin
        d.wr_reg = instr[15:11];
        d.regwrite = 1'b1;
        case (funct)
          F_ADD: d.comando = ALU_ADD;
          F_SUB: d.comando = ALU_SUB;
          F_AND: d.comando = ALU_AND;
          F_OR:  d.comando = ALU_OR;
          F_NOR: d.comando = ALU_NOR;
`ifdef ALU_ISSUE_MULT_EN
          MULT_FUNCT: d.comando = ALU_MUL;
`else
          MULT_FUNCT: illegal = 1'b1;
`endif
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        d.comando = ALU_ADD;
        d.alusrc = 1'b1;
        d.regwrite = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        d.comando = op == OP_ANDI ? ALU_AND : ALU_OR;
        d.alusrc = 1'b1;
        d.imediato = {16'h0, instr[15:0]};
        d.regwrite = 1'b1;
      end
      OP_LW: begin
        d.comando = ALU_ADD;
        d.alusrc = 1'b1;
        d.memread = 1'b1;
        d.regwrite = 1'b1;
      end
      OP_SW: begin
        d.comando = ALU_ADD;
        d.alusrc = 1'b1;
        d.memwrite = 1'b1;
      end
      OP_BEQ: begin
        d.comando = ALU_SUB;
        d.branch = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode-and-issue stage with a 2-entry skid buffer between decode and execute
// Optional multiply decode is enabled by defining ALU_ISSUE_MULT_EN.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [3:0]  comando,
  output logic        alusrc,
  output logic [31:0] valor1,
  output logic [31:0] valor2,
  output logic [31:0] imediato,
  output logic [4:0]  wr_reg,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        branch,
  output logic        illegal
);
  entry_t dec, head, tail;
  state_t state;
  logic dec_ill, take, acc, con;
  alu_decode u_dec (
    .instr   (instr),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .d       (dec),
    .illegal (dec_ill)
  );
  assign take = id_valid && id_ready;
  assign acc = take && !dec_ill;
  assign con = ex_valid && ex_ready;
  // head is the entry presented to execute; tail only holds the second entry while FULL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      head <= '0;
      tail <= '0;
      ex_valid <= 1'b0;
      id_ready <= 1'b1;
      illegal <= 1'b0;
    end else if (flush) begin
      state <= EMPTY;
      ex_valid <= 1'b0;
      id_ready <= 1'b1;
      illegal <= 1'b0;
    end else begin
      illegal <= take && dec_ill;
      case (state)
        EMPTY: if (acc) begin
          head <= dec;
          state <= ONE;
          ex_valid <= 1'b1;
        end
        ONE: if (acc && con) head <= dec;
        else if (acc) begin
          tail <= dec;
          state <= FULL;
          id_ready <= 1'b0;
        end else if (con) begin
          state <= EMPTY;
          ex_valid <= 1'b0;
        end
        FULL: if (con) begin
          head <= tail;
          state <= ONE;
          id_ready <= 1'b1;
        end
        default: state <= EMPTY;
      endcase
    end
  end
  assign comando = head.comando;
  assign alusrc = head.alusrc;
  assign valor1 = head.valor1;
  assign valor2 = head.valor2;
  assign imediato = head.imediato;
  assign wr_reg = head.wr_reg;
  assign regwrite = head.regwrite;
  assign memread = head.memread;
  assign memwrite = head.memwrite;
  assign branch = head.branch;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: vector table, hand sequences and randomized queue-model check of alu_issue
module tb_alu_issue;
  logic clk = 0, rst_n = 1, id_valid = 0, flush = 0, ex_ready = 0;
  logic [31:0] instr = 0, rs_val = 0, rt_val = 0;
  logic id_ready, ex_valid, alusrc, regwrite, memread, memwrite, branch, illegal;
  logic [3:0] comando;
  logic [31:0] valor1, valor2, imediato;
  logic [4:0] wr_reg;
  int checks = 0, errors = 0;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .comando(comando), .alusrc(alusrc), .valor1(valor1), .valor2(valor2), .imediato(imediato),
    .wr_reg(wr_reg), .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
    .branch(branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  typedef struct {
    logic ok;
    logic [3:0] cmd;
    logic src;
    logic [31:0] imm;
    logic [4:0] wr;
    logic rw, mr, mw, br;
  } dec_t;

  // reference decode straight from the instruction-set rules
  function automatic dec_t ref_dec(input logic [31:0] i);
    dec_t r;
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    r = '{1'b1, 4'h0, 1'b0, {{16{i[15]}}, i[15:0]}, i[20:16], 1'b0, 1'b0, 1'b0, 1'b0};
    if (op == 6'h00) begin
      r.wr = i[15:11];
      r.rw = 1;
      if (fn == 6'h20) r.cmd = 4'b0010;
      else if (fn == 6'h22) r.cmd = 4'b0110;
      else if (fn == 6'h24) r.cmd = 4'b0000;
      else if (fn == 6'h25) r.cmd = 4'b0001;
      else if (fn == 6'h27) r.cmd = 4'b1100;
`ifdef ALU_ISSUE_MULT_EN
      else if (fn == 6'h18) r.cmd = 4'b0111;
`endif
      else r.ok = 0;
    end else if (op == 6'h08) begin r.cmd = 4'b0010; r.src = 1; r.rw = 1; end
    else if (op == 6'h0C) begin r.cmd = 4'b0000; r.src = 1; r.rw = 1; r.imm = {16'h0, i[15:0]}; end
    else if (op == 6'h0D) begin r.cmd = 4'b0001; r.src = 1; r.rw = 1; r.imm = {16'h0, i[15:0]}; end
    else if (op == 6'h23) begin r.cmd = 4'b0010; r.src = 1; r.rw = 1; r.mr = 1; end
    else if (op == 6'h2B) begin r.cmd = 4'b0010; r.src = 1; r.mw = 1; end
    else if (op == 6'h04) begin r.cmd = 4'b0110; r.br = 1; end
    else r.ok = 0;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0] ops [8];
    logic [5:0] fns [7];
    int k;
    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h18, 6'h3A};
    r = $urandom;
    k = $urandom_range(0, 8);
    if (k < 8) r[31:26] = ops[k];
    if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 6)];
    return r;
  endfunction

  typedef struct { logic [31:0] i, a, b; } txn_t;
  txn_t q[$];

  task automatic check_head(input txn_t t);
    dec_t e;
    e = ref_dec(t.i);
    chk("rnd_comando", {28'h0, comando}, {28'h0, e.cmd});
    chk("rnd_alusrc", {31'h0, alusrc}, {31'h0, e.src});
    chk("rnd_imediato", imediato, e.imm);
    chk("rnd_valor1", valor1, t.a);
    chk("rnd_valor2", valor2, t.b);
    if (e.rw) chk("rnd_wr_reg", {27'h0, wr_reg}, {27'h0, e.wr});
    chk("rnd_flags", {28'h0, regwrite, memread, memwrite, branch}, {28'h0, e.rw, e.mr, e.mw, e.br});
  endtask

  typedef struct {
    logic [31:0] i, a, b, imm;
    logic [3:0] cmd;
    logic src;
    logic [4:0] wr;
    logic rw, mr, mw, br;
  } vec_t;
  vec_t tv [11];

  initial begin
    txn_t t;
    dec_t e;
    logic acc, con, mill;
    tv[0]  = '{32'h00221820, 32'd5, 32'd7, 32'h00001820, 4'h2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{32'h00A62022, 32'd9, 32'd4, 32'h00002022, 4'h6, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{32'h00223824, 32'hF0F0, 32'hFF00, 32'h00003824, 4'h0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{32'h00224025, 32'h11, 32'h22, 32'h00004025, 4'h1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{32'h00224827, 32'h33, 32'h44, 32'h00004827, 4'hC, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{32'h2025FFFC, 32'h55, 32'h66, 32'hFFFFFFFC, 4'h2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{32'h30468001, 32'h77, 32'h88, 32'h00008001, 4'h0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{32'h34278001, 32'h99, 32'hAA, 32'h00008001, 4'h1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{32'h8C2AFFF8, 32'h1000, 32'h2000, 32'hFFFFFFF8, 4'h2, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{32'hAC2B0010, 32'h3000, 32'h4000, 32'h00000010, 4'h2, 1'b1, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[10] = '{32'h1022FFFF, 32'h5000, 32'h6000, 32'hFFFFFFFF, 4'h6, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};

    #1 rst_n = 0;
    #1;
    chk("rst_ex_valid", {31'h0, ex_valid}, 0);
    chk("rst_id_ready", {31'h0, id_ready}, 1);
    chk("rst_illegal", {31'h0, illegal}, 0);
    chk("rst_comando", {28'h0, comando}, 0);
    chk("rst_data", valor1 | valor2 | imediato, 0);
    chk("rst_flags", {26'h0, wr_reg == 0, alusrc, regwrite, memread, memwrite, branch}, 32'h20);
    @(negedge clk) rst_n = 1;

    foreach (tv[k]) begin
      @(negedge clk);
      id_valid = 1; ex_ready = 1; instr = tv[k].i; rs_val = tv[k].a; rt_val = tv[k].b;
      @(negedge clk);
      id_valid = 0;
      chk("vec_ex_valid", {31'h0, ex_valid}, 1);
      chk("vec_comando", {28'h0, comando}, {28'h0, tv[k].cmd});
      chk("vec_alusrc", {31'h0, alusrc}, {31'h0, tv[k].src});
      chk("vec_imediato", imediato, tv[k].imm);
      chk("vec_valor1", valor1, tv[k].a);
      chk("vec_valor2", valor2, tv[k].b);
      if (tv[k].rw) chk("vec_wr_reg", {27'h0, wr_reg}, {27'h0, tv[k].wr});
      chk("vec_flags", {28'h0, regwrite, memread, memwrite, branch},
          {28'h0, tv[k].rw, tv[k].mr, tv[k].mw, tv[k].br});
    end

    // back-pressure: three offered, two held, third waits, all issue in order
    @(negedge clk);
    ex_ready = 0; id_valid = 1; instr = 32'h00221820; rs_val = 1; rt_val = 11;
    @(negedge clk);
    chk("bp_one_valid", {30'h0, ex_valid, id_ready}, 3);
    chk("bp_one_v1", valor1, 1);
    instr = 32'h00A62022; rs_val = 2; rt_val = 22;
    @(negedge clk);
    chk("bp_full_ready", {31'h0, id_ready}, 0);
    chk("bp_full_v1", valor1, 1);
    instr = 32'h00224025; rs_val = 3; rt_val = 33;
    @(negedge clk);
    chk("bp_stall_ready", {31'h0, id_ready}, 0);
    chk("bp_stall_data", {valor1[15:0], valor2[15:0]}, {16'd1, 16'd11});
    chk("bp_stall_cmd", {28'h0, comando}, 2);
    ex_ready = 1;
    @(negedge clk);
    chk("bp_second", {valor1[15:0], valor2[15:0]}, {16'd2, 16'd22});
    chk("bp_second_cmd", {28'h0, comando}, 6);
    chk("bp_second_ready", {31'h0, id_ready}, 1);
    @(negedge clk);
    chk("bp_third", {valor1[15:0], valor2[15:0]}, {16'd3, 16'd33});
    chk("bp_third_cmd", {28'h0, comando}, 1);
    chk("bp_third_valid", {31'h0, ex_valid}, 1);
    id_valid = 0;
    @(negedge clk);
    chk("bp_drained", {31'h0, ex_valid}, 0);

    // flush while full with an instruction offered
    ex_ready = 0; id_valid = 1; instr = 32'h00221820; rs_val = 4;
    @(negedge clk);
    rs_val = 5;
    @(negedge clk);
    chk("fl_full", {31'h0, id_ready}, 0);
    instr = 32'h2025FFFC; rs_val = 6; flush = 1;
    @(negedge clk);
    flush = 0; id_valid = 0;
    chk("fl_state", {29'h0, ex_valid, id_ready, illegal}, 2);
    ex_ready = 1;
    @(negedge clk);
    chk("fl_no_issue", {31'h0, ex_valid}, 0);
    instr = 32'hFC000000; id_valid = 1; flush = 1;
    @(negedge clk);
    flush = 0; id_valid = 0;
    chk("fl_ill_suppressed", {30'h0, illegal, ex_valid}, 0);

    // unknown opcode
    @(negedge clk);
    instr = 32'hFC000000; id_valid = 1;
    @(negedge clk);
    id_valid = 0;
    chk("ill_pulse", {30'h0, illegal, ex_valid}, 2);
    @(negedge clk);
    chk("ill_one_cycle", {30'h0, illegal, ex_valid}, 0);

    // multiply funct
    instr = 32'h00221818; rs_val = 9; rt_val = 3; id_valid = 1;
    @(negedge clk);
    id_valid = 0;
`ifdef ALU_ISSUE_MULT_EN
    chk("mul_issue", {27'h0, comando, ex_valid}, {27'h0, 4'b0111, 1'b1});
    chk("mul_illegal", {31'h0, illegal}, 0);
`else
    chk("mul_illegal", {30'h0, illegal, ex_valid}, 2);
`endif
    @(negedge clk);

    // asynchronous reset while full
    ex_ready = 0; id_valid = 1; instr = 32'h2025FFFC; rs_val = 7;
    @(negedge clk);
    instr = 32'h8C2AFFF8;
    @(negedge clk);
    id_valid = 0;
    chk("ar_full", {31'h0, id_ready}, 0);
    #2 rst_n = 0;
    #1;
    chk("ar_ctrl", {29'h0, ex_valid, id_ready, illegal}, 2);
    chk("ar_data", valor1 | imediato | {28'h0, comando}, 0);
    chk("ar_flags", {27'h0, alusrc, regwrite, memread, memwrite, branch}, 0);
    @(negedge clk) rst_n = 1;

    // randomized traffic against a queue model
    mill = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      chk("rnd_ex_valid", {31'h0, ex_valid}, {31'h0, q.size() != 0});
      chk("rnd_id_ready", {31'h0, id_ready}, {31'h0, q.size() < 2});
      chk("rnd_illegal", {31'h0, illegal}, {31'h0, mill});
      if (q.size() != 0) check_head(q[0]);
      id_valid = $urandom_range(0, 3) != 0;
      ex_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 29) == 0;
      instr = rand_instr();
      rs_val = $urandom;
      rt_val = $urandom;
      acc = id_valid && q.size() < 2;
      con = q.size() != 0 && ex_ready;
      e = ref_dec(instr);
      if (flush) begin
        q.delete();
        mill = 0;
      end else begin
        mill = acc && !e.ok;
        if (con) void'(q.pop_front());
        t = '{instr, rs_val, rt_val};
        if (acc && e.ok) q.push_back(t);
      end
    end
    @(negedge clk);
    id_valid = 0; flush = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
